// File: rtl/smc_pwm_driver.sv
// H-bridge PWM stage behind the sliding-mode controller.
// Commands pass through saturate -> slew limit -> shadow -> period-aligned apply -> dead-timed PWM pair.
module smc_pwm_driver #(
  parameter int PERIOD   = 1000,
  parameter int DUTY_MAX = 950,
  parameter int SLEW_MAX = 100,
  parameter int DEAD     = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [15:0] u,
  output logic               pwm_a,
  output logic               pwm_b,
  output logic signed [15:0] duty_applied,
  output logic               sat_flag,
  output logic               slew_flag,
  output logic               period_tick
);
  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0]      LAST     = CW'(PERIOD - 1);
  localparam logic [CW-1:0]      DEAD_END = CW'(DEAD);
  localparam logic signed [15:0] DMAX     = 16'(DUTY_MAX);
  localparam logic signed [15:0] SSTEP    = 16'(SLEW_MAX);
  localparam logic signed [17:0] SMAX     = 18'(SLEW_MAX);

  typedef enum logic {ST_RUN, ST_DEAD} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic               wrap, rev, dir_neg, dir_nxt, on_nxt;
  logic               s1_vld, sat_nxt, slew_nxt;
  logic signed [15:0] target, shadow, usat, tgt_nxt, duty_nxt;
  logic signed [17:0] delta;
  logic [15:0]        mag_nxt;

  // Stage 1: clamp, then slew-limit against the running target (18-bit delta cannot wrap)
  always_comb begin
    usat    = u;
    sat_nxt = 1'b0;
    if (u > DMAX) begin
      usat    = DMAX;
      sat_nxt = 1'b1;
    end else if (u < -DMAX) begin
      usat    = -DMAX;
      sat_nxt = 1'b1;
    end
    delta    = {{2{usat[15]}}, usat} - {{2{target[15]}}, target};
    tgt_nxt  = usat;
    slew_nxt = 1'b0;
    if (delta > SMAX) begin
      tgt_nxt  = target + SSTEP;
      slew_nxt = 1'b1;
    end else if (delta < -SMAX) begin
      tgt_nxt  = target - SSTEP;
      slew_nxt = 1'b1;
    end
  end

  // Next-cycle view of counter, duty and FSM so the PWM outputs can be registered
  always_comb begin
    wrap     = (cnt == LAST);
    cnt_nxt  = wrap ? '0 : cnt + 1'b1;
    duty_nxt = wrap ? shadow : duty_applied;
    rev      = wrap && (shadow != 16'sd0) && (shadow[15] != dir_neg);
    dir_nxt  = (wrap && shadow != 16'sd0) ? shadow[15] : dir_neg;
    state_nxt = state;
    if (rev)
      state_nxt = ST_DEAD;
    else if (state == ST_DEAD && cnt_nxt >= DEAD_END)
      state_nxt = ST_RUN;
    mag_nxt = duty_nxt[15] ? 16'(-duty_nxt) : 16'(duty_nxt);
    on_nxt  = (16'(cnt_nxt) < mag_nxt) && (state_nxt == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      target       <= '0;
      shadow       <= '0;
      s1_vld       <= 1'b0;
      duty_applied <= '0;
      dir_neg      <= 1'b0;
      state        <= ST_RUN;
      pwm_a        <= 1'b0;
      pwm_b        <= 1'b0;
      sat_flag     <= 1'b0;
      slew_flag    <= 1'b0;
      period_tick  <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      period_tick <= wrap;
      s1_vld      <= start;
      if (start) begin
        target    <= tgt_nxt;
        sat_flag  <= sat_nxt;
        slew_flag <= slew_nxt;
      end
      // a shadow write landing on the wrap edge is picked up one period later
      if (s1_vld) shadow <= target;
      duty_applied <= duty_nxt;
      dir_neg      <= dir_nxt;
      state        <= state_nxt;
      pwm_a        <= on_nxt && !dir_nxt;
      pwm_b        <= on_nxt && dir_nxt;
    end
  end
endmodule

// File: tb/tb_smc_pwm_driver.sv
// Randomized scoreboard bench for smc_pwm_driver: command flags and per-period
// PWM on-time are predicted from the block's rules and compared as the DUT presents them.
module tb_smc_pwm_driver;
  localparam int PERIOD = 1000;
  localparam int DM     = 950;
  localparam int SM     = 100;
  localparam int DEAD   = 20;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic signed [15:0] u = '0;
  logic               pwm_a, pwm_b, sat_flag, slew_flag, period_tick;
  logic signed [15:0] duty_applied;

  smc_pwm_driver #(.PERIOD(PERIOD), .DUTY_MAX(DM), .SLEW_MAX(SM), .DEAD(DEAD)) dut (
    .clk(clk), .rst(rst), .start(start), .u(u),
    .pwm_a(pwm_a), .pwm_b(pwm_b), .duty_applied(duty_applied),
    .sat_flag(sat_flag), .slew_flag(slew_flag), .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  typedef struct {bit sat; bit slew;} flag_t;
  typedef struct {int per; int val;} upd_t;
  typedef struct {int duty; int a_cnt; int b_cnt; int first;} per_t;

  flag_t flag_q[$];
  upd_t  upd_q[$];
  per_t  per_q[$];

  int errors = 0, checks = 0;
  int tcnt = 0, pidx = 0, mtarget = 0, cur_duty = 0;
  bit mdir_neg = 1'b0, start_seen = 1'b0, mon_en = 1'b1;
  per_t cur_exp = '{0, 0, 0, -1};
  int overlap = 0, a_acc = 0, b_acc = 0, first_on = -1, last_duty = 0;
  int mag, on_t;
  bit rev;
  upd_t upd_tmp;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (period %0d cnt %0d)", name, act, exp, pidx, tcnt);
    end
  endtask

  // Reference model: time base plus the duty each period should run with
  always @(posedge clk) begin
    if (!rst) begin
      start_seen = start;
      tcnt = (tcnt == PERIOD - 1) ? 0 : tcnt + 1;
      if (tcnt == 0) begin
        per_q.push_back(cur_exp);
        pidx++;
        while (upd_q.size() > 0 && upd_q[0].per <= pidx) begin
          upd_tmp  = upd_q.pop_front();
          cur_duty = upd_tmp.val;
        end
        rev = 1'b0;
        if (cur_duty != 0) begin
          rev      = ((cur_duty < 0) != mdir_neg);
          mdir_neg = (cur_duty < 0);
        end
        mag  = (cur_duty < 0) ? -cur_duty : cur_duty;
        on_t = rev ? ((mag > DEAD) ? mag - DEAD : 0) : mag;
        cur_exp.duty  = cur_duty;
        cur_exp.a_cnt = (cur_duty > 0) ? on_t : 0;
        cur_exp.b_cnt = (cur_duty < 0) ? on_t : 0;
        cur_exp.first = (on_t > 0) ? (rev ? DEAD : 0) : -1;
      end
    end
  end

  // Monitor: pops expectations as the DUT presents flags and period ticks
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (pwm_a && pwm_b) begin
        overlap++;
        $display("FAIL overlap: pwm_a and pwm_b both high at period %0d cnt %0d", pidx, tcnt);
      end
      if (start_seen) begin
        if (flag_q.size() == 0) chk("flag_q_underflow", 1, 0);
        else begin
          flag_t f;
          f = flag_q.pop_front();
          chk("sat_flag", int'(sat_flag), int'(f.sat));
          chk("slew_flag", int'(slew_flag), int'(f.slew));
        end
      end
      if (period_tick || (tcnt == 0 && pidx > 0)) begin
        chk("tick_at_wrap", int'(period_tick) + 2 * int'(tcnt == 0), 3);
        if (period_tick) begin
          if (per_q.size() == 0) chk("per_q_underflow", 1, 0);
          else begin
            per_t e;
            e = per_q.pop_front();
            chk("duty_applied", last_duty, e.duty);
            chk("pwm_a_on", a_acc, e.a_cnt);
            chk("pwm_b_on", b_acc, e.b_cnt);
            chk("first_on", first_on, e.first);
          end
          a_acc = 0; b_acc = 0; first_on = -1;
        end
      end
      if (pwm_a) a_acc++;
      if (pwm_b) b_acc++;
      if ((pwm_a || pwm_b) && first_on < 0) first_on = tcnt;
      last_duty = duty_applied;
    end
  end

  // Issue one command in the current cycle; start is left high for back-to-back use
  task automatic send(input int v);
    int us, dl;
    flag_t f;
    upd_t e;
    us = (v > DM) ? DM : (v < -DM) ? -DM : v;
    f.sat = (us != v);
    dl = us - mtarget;
    if (dl > SM) begin mtarget += SM; f.slew = 1'b1; end
    else if (dl < -SM) begin mtarget -= SM; f.slew = 1'b1; end
    else begin mtarget = us; f.slew = 1'b0; end
    flag_q.push_back(f);
    e.per = pidx + ((tcnt <= PERIOD - 3) ? 1 : 2);
    e.val = mtarget;
    upd_q.push_back(e);
    start = 1'b1;
    u = 16'(v);
    @(negedge clk);
  endtask

  task automatic burst(input int v, input int n);
    for (int i = 0; i < n; i++) send(v);
    start = 1'b0;
  endtask

  task automatic wait_at(input int p, input int c);
    int budget;
    budget = 5 * PERIOD;
    do begin
      @(negedge clk);
      budget--;
    end while (!(pidx == p && tcnt == c) && budget > 0);
    if (budget == 0) chk("wait_at_timeout", pidx * PERIOD + tcnt, p * PERIOD + c);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_pwm_a", int'(pwm_a), 0);
    chk("rst_pwm_b", int'(pwm_b), 0);
    chk("rst_duty", int'(duty_applied), 0);
    chk("rst_sat", int'(sat_flag), 0);
    chk("rst_slew", int'(slew_flag), 0);
    chk("rst_tick", int'(period_tick), 0);
    rst = 1'b0;

    wait_at(3, 100);  burst(80, 1);            // small step
    wait_at(4, 100);  burst(0, 1);
    wait_at(4, 200);  burst(2000, 6);          // sat + slew ramp to 600
    wait_at(5, 100);  burst(300, 3);           // back down to +300
    wait_at(6, 100);  burst(-50, 4);           // reversal to -50
    wait_at(8, 100);  burst(100, 2);
    wait_at(9, 100);  burst(0, 1);             // +100 -> 0 -> +100, no dead time
    wait_at(10, 100); burst(100, 1);
    wait_at(11, 998); burst(200, 1);           // shadow write on the wrap edge
    wait_at(13, 997); burst(300, 1);
    wait_at(14, 999); burst(350, 1);

    for (int k = 0; k < 12; k++) begin
      int c, n, v;
      c = ($urandom_range(0, 4) == 0) ? int'($urandom_range(997, 999)) : int'($urandom_range(10, 996));
      n = int'($urandom_range(0, 3));
      wait_at(16 + k, c);
      for (int i = 0; i < n; i++) begin
        v = ($urandom_range(0, 5) == 0) ? (($urandom_range(0, 1) == 1) ? 32767 : -32768)
                                        : int'($urandom_range(0, 4000)) - 2000;
        send(v);
      end
      start = 1'b0;
    end

    wait_at(28, 100); burst(-32768, 20);       // full negative
    wait_at(29, 100); burst(32767, 20);        // full positive with reversal
    wait_at(31, 40);
    chk("pre_reset_pwm_a", int'(pwm_a), 1);
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_pwm_a", int'(pwm_a), 0);
    chk("async_pwm_b", int'(pwm_b), 0);
    chk("async_duty", int'(duty_applied), 0);
    chk("async_sat", int'(sat_flag), 0);
    chk("async_slew", int'(slew_flag), 0);
    chk("async_tick", int'(period_tick), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("overlap_count", overlap, 0);
    chk("flag_q_drained", flag_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
